wb_irq_conditioner: RTL and testbench

- Parametrised successor to the per-pin push-button debouncers that feed the CPU interrupt vector.
- Conditions NUM_CH asynchronous external interrupt pins: 2-flop synchroniser, per-channel debounce counter, per-channel edge/level detect.
- Latches detected events into a W1C pending register, gates them with a mask, and drives per-channel and aggregate IRQ lines.
- Sits as a Wishbone classic slave on the intercon; irq_vec_o is concatenated into the CPU interrupt vector in place of raw debounced pins.

---
 rtl/wb_irq_conditioner.sv | 211 +++++++++++++++++++++
 tb/tb_wb_irq_conditioner.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_irq_conditioner.sv
// Wishbone interrupt conditioner: per-pin sync, debounce, edge/level detect, W1C pending, mask.
// Define IRQ_CNT_EN to add per-channel saturating 8-bit event counters at 0x10 + 4*ch.
module wb_irq_conditioner #(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned CNT_W      = 16,
    parameter logic [1:0]  RST_MODE   = 2'b01
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [NUM_CH-1:0] irq_pad_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              wb_rty_o,
    output logic [NUM_CH-1:0] irq_vec_o,
    output logic              irq_o,
    output logic [NUM_CH-1:0] clean_o
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [NUM_CH-1:0]   sync_q1;
    logic [NUM_CH-1:0]   sync_q2;
    logic [NUM_CH-1:0]   clean_q;
    logic [CNT_W-1:0]    deb_cnt_q [NUM_CH];
    logic [NUM_CH-1:0]   flip;
    logic [NUM_CH-1:0]   rise;
    logic [NUM_CH-1:0]   fall;
    logic [NUM_CH-1:0]   event_hit;

    logic [NUM_CH-1:0]   pending_q;
    logic [NUM_CH-1:0]   mask_q;
    logic [2*NUM_CH-1:0] mode_q;
    logic [NUM_CH-1:0]   pend_clr;

    logic [3:0]          reg_idx;
    logic                addr_in_window;
    logic                reg_hit;
    logic                bus_req;
    logic                acc_ok;
    logic                acc_bad;
    logic                wr_en;
    logic [31:0]         rd_data;
    logic                unused_bits;

    // Byte selects and word-offset bits are don't-care: full-word access only.
    assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_pad_i;
            sync_q2 <= sync_q1;
        end
    end

    always_comb begin
        flip = '0;
        rise = '0;
        fall = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            flip[i] = (sync_q2[i] != clean_q[i]) && (deb_cnt_q[i] == DEB_LAST);
            rise[i] = flip[i] & sync_q2[i];
            fall[i] = flip[i] & ~sync_q2[i];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            clean_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            clean_q <= clean_q ^ flip;
            for (int i = 0; i < NUM_CH; i++) begin
                if ((sync_q2[i] == clean_q[i]) || flip[i]) begin
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Level mode uses the registered clean level, so it fires every cycle the level is high.
    always_comb begin
        event_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode_q[2*i +: 2])
                2'b00:   event_hit[i] = clean_q[i];
                2'b01:   event_hit[i] = rise[i];
                2'b10:   event_hit[i] = fall[i];
                default: event_hit[i] = rise[i] | fall[i];
            endcase
        end
    end

    // The intercon hands us a local offset; anything at or above 0x40 is unmapped.
    assign reg_idx        = wb_adr_i[5:2];
    assign addr_in_window = (wb_adr_i[31:6] == '0);

    always_comb begin
        reg_hit = 1'b0;
        if (addr_in_window) begin
            if (reg_idx < 4'd4) begin
                reg_hit = 1'b1;
            end
`ifdef IRQ_CNT_EN
            else begin
                reg_hit = 1'b1;
            end
`endif
        end
    end

    assign bus_req = wb_stb_i & wb_cyc_i & ~wb_ack_o & ~wb_err_o;
    assign acc_ok  = bus_req & reg_hit;
    assign acc_bad = bus_req & ~reg_hit;
    assign wr_en   = acc_ok & wb_we_i;

    assign pend_clr = (wr_en && (reg_idx == 4'd1)) ? wb_dat_i[NUM_CH-1:0] : '0;

`ifdef IRQ_CNT_EN
    logic [7:0] evt_cnt_q [NUM_CH];

    // Clear beats increment; only the first twelve channels fit the 0x10-0x3C window.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                evt_cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_en && (int'(reg_idx) == c + 4)) begin
                    evt_cnt_q[c] <= '0;
                end else if (event_hit[c] && (evt_cnt_q[c] != 8'hFF)) begin
                    evt_cnt_q[c] <= evt_cnt_q[c] + 8'd1;
                end
            end
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            4'd0: rd_data[NUM_CH-1:0]   = clean_q;
            4'd1: rd_data[NUM_CH-1:0]   = pending_q;
            4'd2: rd_data[NUM_CH-1:0]   = mask_q;
            4'd3: rd_data[2*NUM_CH-1:0] = mode_q;
            default: begin
`ifdef IRQ_CNT_EN
                for (int c = 0; c < NUM_CH; c++) begin
                    if (int'(reg_idx) == c + 4) begin
                        rd_data[7:0] = evt_cnt_q[c];
                    end
                end
`endif
            end
        endcase
    end

    // Set wins over a coincident write-1-to-clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~pend_clr) | event_hit;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            mask_q   <= '0;
            mode_q   <= {NUM_CH{RST_MODE}};
        end else begin
            wb_ack_o <= acc_ok;
            wb_err_o <= acc_bad;
            if (acc_ok) begin
                wb_dat_o <= rd_data;
            end else if (acc_bad) begin
                wb_dat_o <= '0;
            end
            if (wr_en && (reg_idx == 4'd2)) begin
                mask_q <= wb_dat_i[NUM_CH-1:0];
            end
            if (wr_en && (reg_idx == 4'd3)) begin
                mode_q <= wb_dat_i[2*NUM_CH-1:0];
            end
        end
    end

    assign irq_vec_o = pending_q & mask_q;
    assign irq_o     = |irq_vec_o;
    assign clean_o   = clean_q;
    assign wb_rty_o  = 1'b0;

endmodule

// File: tb/tb_wb_irq_conditioner.sv
// Self-checking bench for wb_irq_conditioner: register table, directed corner sequences,
// and randomized pads/bus traffic checked against a window-based behavioural model.
module tb_wb_irq_conditioner;

    localparam int NUM_CH = 3;
    localparam int DEB    = 16;
`ifdef IRQ_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i;
    logic [NUM_CH-1:0] irq_pad_i;
    logic [31:0]       wb_adr_i;
    logic [31:0]       wb_dat_i;
    logic [31:0]       wb_dat_o;
    logic [3:0]        wb_sel_i;
    logic              wb_we_i;
    logic              wb_stb_i;
    logic              wb_cyc_i;
    logic              wb_ack_o;
    logic              wb_err_o;
    logic              wb_rty_o;
    logic [NUM_CH-1:0] irq_vec_o;
    logic              irq_o;
    logic [NUM_CH-1:0] clean_o;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_irq_conditioner #(
        .NUM_CH(NUM_CH), .DEB_CYCLES(DEB), .CNT_W(16), .RST_MODE(2'b01)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .irq_pad_i(irq_pad_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i),
        .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .wb_rty_o(wb_rty_o), .irq_vec_o(irq_vec_o), .irq_o(irq_o), .clean_o(clean_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: clean takes the opposite level once the synchronised pad
    // (pad two edges ago) has shown that level for DEB consecutive samples.
    logic [NUM_CH-1:0]   hist[$];
    logic [NUM_CH-1:0]   m_clean, m_pend, m_mask;
    logic [2*NUM_CH-1:0] m_mode;
    int                  m_cnt [NUM_CH];
    bit                  m_ack, m_err, m_rd;
    logic [31:0]         m_rdata;
    logic [NUM_CH-1:0]   pad_q;

    function automatic bit addr_ok(input logic [31:0] a);
        if (a < 32'h10) return 1'b1;
        if (a < 32'h40) return CNT_EN;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int off = int'(a[5:2]);
        case (off)
            0: return 32'(m_clean);
            1: return 32'(m_pend);
            2: return 32'(m_mask);
            3: return 32'(m_mode);
            default: begin
                if (CNT_EN && (off - 4 < NUM_CH)) return 32'(m_cnt[off-4]);
                return 32'h0;
            end
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (DEB + 2) hist.push_back('0);
        m_clean = '0; m_pend = '0; m_mask = '0; m_mode = {NUM_CH{2'b01}};
        for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
        m_ack = 0; m_err = 0; m_rd = 0; m_rdata = '0;
    endtask

    task automatic model_edge(input logic [NUM_CH-1:0] pad, input bit req, input bit we,
                              input logic [31:0] adr, input logic [31:0] dat);
        logic [NUM_CH-1:0]   ev, nclean, clr, nmask;
        logic [2*NUM_CH-1:0] nmode;
        bit                  acc, stable, r, f;
        bit                  cnt_clr [NUM_CH];
        int                  n, off;
        hist.push_back(pad);
        n = hist.size();
        nclean = m_clean; ev = '0; clr = '0; nmask = m_mask; nmode = m_mode;
        for (int c = 0; c < NUM_CH; c++) begin
            stable = 1'b1;
            for (int j = n - DEB - 2; j <= n - 3; j++)
                if (hist[j][c] == m_clean[c]) stable = 1'b0;
            r = stable & ~m_clean[c];
            f = stable & m_clean[c];
            if (stable) nclean[c] = ~m_clean[c];
            case (m_mode[2*c +: 2])
                2'b00:   ev[c] = m_clean[c];
                2'b01:   ev[c] = r;
                2'b10:   ev[c] = f;
                default: ev[c] = r | f;
            endcase
            cnt_clr[c] = 1'b0;
        end
        acc = req && !m_ack && !m_err;
        off = int'(adr[5:2]);
        m_rd = 1'b0;
        if (acc && addr_ok(adr)) begin
            m_rdata = m_read(adr);
            m_ack = 1'b1; m_err = 1'b0; m_rd = !we;
            if (we) begin
                if (off == 1) clr = dat[NUM_CH-1:0];
                if (off == 2) nmask = dat[NUM_CH-1:0];
                if (off == 3) nmode = dat[2*NUM_CH-1:0];
                if (off >= 4 && off - 4 < NUM_CH) cnt_clr[off-4] = 1'b1;
            end
        end else if (acc) begin
            m_ack = 1'b0; m_err = 1'b1;
        end else begin
            m_ack = 1'b0; m_err = 1'b0;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (cnt_clr[c]) m_cnt[c] = 0;
            else if (ev[c] && m_cnt[c] < 255) m_cnt[c]++;
        end
        m_pend  = (m_pend & ~clr) | ev;
        m_clean = nclean;
        m_mask  = nmask;
        m_mode  = nmode;
        while (hist.size() > DEB + 4) void'(hist.pop_front());
    endtask

    task automatic step(input logic [NUM_CH-1:0] pad, input bit req, input bit we,
                        input logic [31:0] adr, input logic [31:0] dat, input bit hold);
        irq_pad_i = pad; wb_stb_i = req; wb_cyc_i = req; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat;
        @(posedge wb_clk_i);
        model_edge(pad, req, we, adr, dat);
        @(negedge wb_clk_i);
        check("clean_o", 32'(clean_o), 32'(m_clean));
        check("irq_vec_o", 32'(irq_vec_o), 32'(m_pend & m_mask));
        check("irq_o", 32'(irq_o), 32'(|(m_pend & m_mask)));
        check("wb_ack_o", 32'(wb_ack_o), 32'(m_ack));
        check("wb_err_o", 32'(wb_err_o), 32'(m_err));
        if (m_rd) check("wb_dat_o", wb_dat_o, m_rdata);
        if (!hold) begin
            wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(pad_q, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        step(pad_q, 1'b1, 1'b1, adr, dat, 1'b0);
        idle(1);
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
        step(pad_q, 1'b1, 1'b0, adr, 32'h0, 1'b0);
        check({name, "_ack"}, 32'(wb_ack_o), 32'h1);
        check(name, wb_dat_o, exp);
        idle(1);
    endtask

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        bit          exp_ack;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int hold_left [NUM_CH];
        bit last_req;

        wb_rst_i = 1'b1; irq_pad_i = '0; wb_adr_i = '0; wb_dat_i = '0;
        wb_sel_i = 4'hF; wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        pad_q = '0;
        #12;
        check("rst_ack", 32'(wb_ack_o), 32'h0);
        check("rst_err", 32'(wb_err_o), 32'h0);
        check("rst_rty", 32'(wb_rty_o), 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_irq_vec", 32'(irq_vec_o), 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_clean", 32'(clean_o), 32'h0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        model_reset();

        // Register map vectors, pads idle
        vecs.push_back('{0, 32'h00, 32'h0,        1, 0, 32'h0});
        vecs.push_back('{0, 32'h04, 32'h0,        1, 0, 32'h0});
        vecs.push_back('{0, 32'h08, 32'h0,        1, 0, 32'h0});
        vecs.push_back('{0, 32'h0C, 32'h0,        1, 0, 32'h15});
        vecs.push_back('{1, 32'h08, 32'hFFFFFFFF, 1, 0, 32'h0});
        vecs.push_back('{0, 32'h08, 32'h0,        1, 0, 32'h7});
        vecs.push_back('{1, 32'h0C, 32'hFFFFFFFF, 1, 0, 32'h0});
        vecs.push_back('{0, 32'h0C, 32'h0,        1, 0, 32'h3F});
        vecs.push_back('{1, 32'h0C, 32'h15,       1, 0, 32'h0});
        vecs.push_back('{0, 32'h0C, 32'h0,        1, 0, 32'h15});
        vecs.push_back('{1, 32'h00, 32'hFFFFFFFF, 1, 0, 32'h0});
        vecs.push_back('{0, 32'h00, 32'h0,        1, 0, 32'h0});
        vecs.push_back('{0, 32'h40, 32'h0,        0, 1, 32'h0});
        vecs.push_back('{1, 32'h44, 32'hF,        0, 1, 32'h0});
`ifdef IRQ_CNT_EN
        vecs.push_back('{0, 32'h10, 32'h0,        1, 0, 32'h0});
        vecs.push_back('{0, 32'h3C, 32'h0,        1, 0, 32'h0});
`else
        vecs.push_back('{0, 32'h10, 32'h0,        0, 1, 32'h0});
        vecs.push_back('{1, 32'h3C, 32'h1,        0, 1, 32'h0});
`endif
        vecs.push_back('{1, 32'h08, 32'h1,        1, 0, 32'h0});
        vecs.push_back('{0, 32'h08, 32'h0,        1, 0, 32'h1});
        foreach (vecs[i]) begin
            step(pad_q, 1'b1, vecs[i].we, vecs[i].adr, vecs[i].dat, 1'b0);
            check($sformatf("vec%0d_ack", i), 32'(wb_ack_o), 32'(vecs[i].exp_ack));
            check($sformatf("vec%0d_err", i), 32'(wb_err_o), 32'(vecs[i].exp_err));
            if (!vecs[i].we && vecs[i].exp_ack)
                check($sformatf("vec%0d_rd", i), wb_dat_o, vecs[i].exp_rd);
            idle(1);
        end

        // Held strobe: ack and err are single-cycle pulses
        step(pad_q, 1'b1, 1'b0, 32'h08, 32'h0, 1'b1);
        step(pad_q, 1'b1, 1'b0, 32'h08, 32'h0, 1'b0);
        check("ack_one_cycle", 32'(wb_ack_o), 32'h0);
        idle(1);
        step(pad_q, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
        check("err_0x40", 32'(wb_err_o), 32'h1);
        check("err_0x40_noack", 32'(wb_ack_o), 32'h0);
        step(pad_q, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        check("err_one_cycle", 32'(wb_err_o), 32'h0);
        idle(1);

        // Pad 0 rises: clean, pending and irq after exactly DEB+2 edges
        pad_q[0] = 1'b1;
        e = 0;
        for (int k = 1; k <= 40; k++) begin
            idle(1);
            if (clean_o[0]) begin
                e = k;
                break;
            end
        end
        check("rise_latency", 32'(e), 32'(DEB + 2));
        check("rise_irq", 32'(irq_o), 32'h1);
        check("rise_irq_vec", 32'(irq_vec_o), 32'h1);
        rd(32'h04, 32'h1, "rise_pending");

        // 10-cycle glitch on pad 1 is filtered
        pad_q[1] = 1'b1;
        idle(10);
        pad_q[1] = 1'b0;
        idle(30);
        check("glitch_clean", 32'(clean_o), 32'h1);
        rd(32'h04, 32'h1, "glitch_pending");

        // Level mode on ch2 cannot be cleared while high
        wr(32'h0C, 32'h05);
        pad_q[2] = 1'b1;
        idle(25);
        wr(32'h04, 32'h4);
        rd(32'h04, 32'h5, "level_w1c_blocked");
        pad_q[2] = 1'b0;
        idle(20);
        wr(32'h04, 32'h4);
        rd(32'h04, 32'h1, "level_w1c_after_release");
        wr(32'h04, 32'h1);
        rd(32'h04, 32'h0, "w1c_ch0");

        // Masked event stays pending; unmasking raises irq next cycle
        wr(32'h08, 32'h0);
        pad_q[0] = 1'b0;
        idle(20);
        pad_q[0] = 1'b1;
        idle(20);
        check("masked_irq", 32'(irq_o), 32'h0);
        rd(32'h04, 32'h1, "masked_pending");
        step(pad_q, 1'b1, 1'b1, 32'h08, 32'h1, 1'b0);
        check("unmask_irq", 32'(irq_o), 32'h1);
        idle(1);

        // W1C coinciding with a rising event: set wins
        wr(32'h04, 32'h1);
        rd(32'h04, 32'h0, "pre_race_pending");
        pad_q[0] = 1'b0;
        idle(20);
        pad_q[0] = 1'b1;
        idle(DEB + 1);
        check("race_clean_before", 32'(clean_o[0]), 32'h0);
        step(pad_q, 1'b1, 1'b1, 32'h04, 32'h1, 1'b0);
        check("race_clean", 32'(clean_o[0]), 32'h1);
        check("race_irq_vec", 32'(irq_vec_o[0]), 32'h1);
        idle(1);
        rd(32'h04, 32'h1, "race_pending");

`ifdef IRQ_CNT_EN
        // Level mode on ch0 drives 300+ events: counter saturates, write clears
        wr(32'h0C, 32'h14);
        idle(300);
        rd(32'h10, 32'hFF, "cnt_saturate");
        pad_q[0] = 1'b0;
        idle(20);
        wr(32'h10, 32'h0);
        rd(32'h10, 32'h0, "cnt_cleared");
        rd(32'h14, 32'h0, "cnt_ch1_idle");
        wr(32'h0C, 32'h15);
`endif

        // Randomized pads and bus traffic against the model
        wr(32'h0C, $urandom);
        wr(32'h08, $urandom);
        for (int c = 0; c < NUM_CH; c++) hold_left[c] = $urandom_range(40, 1);
        last_req = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (hold_left[c] == 0) begin
                    pad_q[c] = ~pad_q[c];
                    hold_left[c] = $urandom_range(40, 1);
                end
                hold_left[c]--;
            end
            if (!last_req && $urandom_range(7, 0) == 0) begin
                case ($urandom_range(5, 0))
                    0: step(pad_q, 1'b1, 1'b0, 32'h04, 32'h0, 1'b0);
                    1: step(pad_q, 1'b1, 1'b0, 32'h00, 32'h0, 1'b0);
                    2: step(pad_q, 1'b1, 1'b1, 32'h04, $urandom, 1'b0);
                    3: step(pad_q, 1'b1, 1'b0, 32'h08, 32'h0, 1'b0);
                    4: step(pad_q, 1'b1, 1'b0, 32'h10 + 32'($urandom_range(3, 0)) * 4, 32'h0, 1'b0);
                    default: step(pad_q, 1'b1, 1'b1, 32'h0C, $urandom, 1'b0);
                endcase
                last_req = 1'b1;
            end else begin
                idle(1);
                last_req = 1'b0;
            end
        end

        // Reset in the middle of an acknowledged transfer
        wr(32'h08, 32'h7);
        wr(32'h0C, 32'h0);
        pad_q = '1;
        idle(25);
        check("pre_rst_irq", 32'(irq_o), 32'h1);
        irq_pad_i = pad_q; wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h04;
        @(posedge wb_clk_i);
        #2;
        check("pre_rst_ack", 32'(wb_ack_o), 32'h1);
        wb_rst_i = 1'b1;
        #1;
        check("midrst_ack", 32'(wb_ack_o), 32'h0);
        check("midrst_irq", 32'(irq_o), 32'h0);
        check("midrst_irq_vec", 32'(irq_vec_o), 32'h0);
        check("midrst_clean", 32'(clean_o), 32'h0);
        check("midrst_dat", wb_dat_o, 32'h0);
        @(negedge wb_clk_i);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        pad_q = '0; irq_pad_i = '0;
        wb_rst_i = 1'b0;
        model_reset();
        rd(32'h04, 32'h0, "post_rst_pending");
        rd(32'h0C, 32'h15, "post_rst_mode");
        rd(32'h08, 32'h0, "post_rst_mask");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
